// File: rtl/sixtn_bit_multiplier_if.sv
// Operand/result bundle for the sequential 8x8 multiplier.
// The caller owns start/A/B; the multiplier drives P/busy/done.
interface sixtn_bit_multiplier_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output A,
        output B,
        input  P,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output P,
        output busy,
        output done
    );
endinterface

// File: rtl/sixtn_bit_multiplier.sv
// Unsigned 8x8 -> 16 shift-and-add multiplier, one partial product per clock.
// Start is accepted in IDLE; P updates eight edges later with a one-cycle done pulse.
module sixtn_bit_multiplier (
    input  logic                    clk,
    input  logic                    reset,
    sixtn_bit_multiplier_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] mcand_reg, mcand_next;
    logic [7:0]  mplier_reg, mplier_next;
    logic [15:0] acc_reg, acc_next;
    logic [2:0]  count_reg, count_next;
    logic [15:0] p_reg, p_next;

    logic [15:0] addend;
    logic [15:0] sum;

    // Partial product: the shifted multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign sum = acc_reg + addend;

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        p_next      = p_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mcand_next  = {8'h00, bus.A};
                    mplier_next = bus.B;
                    acc_next    = 16'h0000;
                    count_next  = 3'd0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                acc_next    = sum;
                mcand_next  = {mcand_reg[14:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[7:1]};
                count_next  = count_reg + 3'd1;
                // Counter reads 7 on the eighth iteration; its sum is the full product.
                if (count_reg == 3'd7) begin
                    p_next     = sum;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            mcand_reg  <= 16'h0000;
            mplier_reg <= 8'h00;
            acc_reg    <= 16'h0000;
            count_reg  <= 3'd0;
            p_reg      <= 16'h0000;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            count_reg  <= count_next;
            p_reg      <= p_next;
        end
    end

    assign bus.P    = p_reg;
    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);

endmodule

// File: tb/tb_sixtn_bit_multiplier.sv
// Directed bench for sixtn_bit_multiplier: expected products are queued at launch
// and popped when done pulses; timing of busy/done is checked alongside.
module tb_sixtn_bit_multiplier;

    logic clk;
    logic reset;

    sixtn_bit_multiplier_if bus ();

    sixtn_bit_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    // mode 0: plain; 1: extra start pulse mid-run; 2: operands change mid-run
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int mode, input string tag);
        logic [15:0] p_before;
        logic [15:0] exp_p;
        int          wait_cyc;
        int          busy_cyc;
        bit          p_moved;
        wait_cyc = 0;
        busy_cyc = 0;
        p_moved  = 1'b0;
        @(negedge clk);
        p_before = bus.P;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back(16'(a) * 16'(b));
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && wait_cyc < 20) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.P !== p_before) p_moved = 1'b1;
            if (mode == 1 && wait_cyc == 3) begin
                bus.start = 1'b1;
                bus.A     = 8'd3;
                bus.B     = 8'd7;
            end
            if (mode == 1 && wait_cyc == 4) bus.start = 1'b0;
            if (mode == 2 && wait_cyc == 3) begin
                bus.A = 8'd1;
                bus.B = 8'd1;
            end
            wait_cyc++;
            @(negedge clk);
        end
        exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(wait_cyc), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd8);
        check({tag, "_p_held"}, 32'(p_moved), 32'd0);
        check({tag, "_product"}, 32'(bus.P), 32'(exp_p));
        $display("[TB] txn %s A=%0d B=%0d P=%0d expected=%0d latency=%0d", tag, a, b, bus.P, exp_p, wait_cyc);
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        int d_at [2];
        int stray;
        logic [15:0] exp_p;

        bus.start = 1'b0;
        bus.A     = 8'd0;
        bus.B     = 8'd0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_p", 32'(bus.P), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        // 9 * (all-ones treated as 255)
        run_op(8'd9, 8'hFF, 0, "a9_bff");
        check("a9_bff_p_low", 32'(bus.P[7:0]), 32'd247);

        run_op(8'd8, 8'd100, 0, "a8_b100");
        check("a8_b100_p_low", 32'(bus.P[7:0]), 32'd32);

        run_op(8'd255, 8'd255, 0, "a255_b255");
        run_op(8'd0, 8'd200, 0, "a0_b200");
        run_op(8'd1, 8'd1, 0, "a1_b1");
        run_op(8'd200, 8'd0, 0, "a200_b0");

        // start while busy is ignored; P remains 2295, then a fresh op gives 21
        run_op(8'd9, 8'd255, 1, "start_while_busy");
        run_op(8'd3, 8'd7, 0, "a3_b7_after_idle");

        // operands latched at start; later changes have no effect
        run_op(8'd9, 8'd255, 2, "operand_change");

        // back-to-back with start held high
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd200;
        bus.B     = 8'd150;
        exp_q.push_back(16'd30000);
        exp_q.push_back(16'd221);
        @(negedge clk);
        bus.A = 8'd17;
        bus.B = 8'd13;
        cyc     = 0;
        ndone   = 0;
        d_at[0] = 0;
        d_at[1] = 0;
        while (ndone < 2 && cyc < 40) begin
            if (bus.done === 1'b1) begin
                exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                check($sformatf("b2b_product_%0d", ndone), 32'(bus.P), 32'(exp_p));
                $display("[TB] txn b2b_%0d P=%0d expected=%0d cycle=%0d", ndone, bus.P, exp_p, cyc);
                d_at[ndone] = cyc;
                ndone++;
                if (ndone == 2) bus.start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("b2b_results_seen", 32'(ndone), 32'd2);
        check("b2b_spacing", 32'(d_at[1] - d_at[0]), 32'd10);
        @(negedge clk);

        // reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd5;
        bus.B     = 8'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_p", 32'(bus.P), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        check("abort_no_done_after", 32'(stray), 32'd0);
        $display("[TB] txn abort_reset P=%0d busy=%0d done=%0d", bus.P, bus.busy, bus.done);

        // recovery after abort
        run_op(8'd123, 8'd45, 0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sixtn_bit_multiplier.md
Name: sixtn_bit_multiplier

Overview:
Sequential unsigned 8x8 -> 16-bit multiplier using a radix-2 shift-and-add datapath, one partial product per clock. It is a small arithmetic unit in the matrix datapath. A caller launches an operation with a start pulse and collects the full 16-bit product when done asserts. Result semantics are identical to the combinational product A*B with both operands treated as unsigned.

Parameters:
None. Operand width is fixed at 8 bits and product width at 16 bits.

Ports:
clk    input   1   system clock; all state updates on the rising edge
reset  input   1   synchronous, active-high reset
start  input   1   request a multiply; sampled only in IDLE
A      input   8   multiplicand, unsigned; latched when start is accepted
B      input   8   multiplier, unsigned; latched when start is accepted
P      output  16  product register; holds the last completed result
busy   output  1   high while an operation is in progress (RUN)
done   output  1   one-cycle pulse when P has just been updated

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). There is no asynchronous path.
- Reset: on any clk edge with reset=1:
  - state goes to IDLE
  - P, busy and done all go to 0
  - internal accumulator, shift registers and counter are cleared
  - reset takes priority over start and over any in-flight operation, so reset mid-operation aborts it and P reads 0.
- States:
  - IDLE: busy=0, done=0. Leaves only when start=1 is sampled.
  - RUN: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE with start=1 at edge E0:
  - latch A into the multiplicand register, zero-extended to 16 bits
  - latch B into the multiplier register
  - clear the accumulator and the 3-bit iteration counter
  - go to RUN
- RUN, each edge:
  - if multiplier bit0=1, accumulator += multiplicand (16-bit, no overflow possible)
  - multiplicand shifts left 1; multiplier shifts right 1; counter increments
  - after the 8th RUN edge (E8): P <= final accumulator value; go to DONE
- DONE: at the next edge, return to IDLE. start is ignored in DONE.
- Timing:
  - done=1 in the cycle after E8, and P is valid from that same cycle.
  - Latency from start-sampling edge to P valid is 8 clocks; back-to-back throughput is 1 result per 10 clocks.
- start while busy or done is ignored. Operand changes on A/B after E0 do not affect the running operation.
- P holds its previous value throughout RUN and changes only at E8 or on reset.
- Arithmetic: fully unsigned; P = A*B exactly, with range 0..65025. An 8-bit all-ones input is the value 255, not -1.
- Boundaries:
  - A=0 or B=0 gives P=0.
  - A=B=255 gives P=65025 (0xFE01).
  - start held high continuously gives a new operation starting each time IDLE is re-entered.

Test Plan:
1. Reset, then start with A=9, B=8'hFF (driven as -1) -> done pulses 8 clocks after the sampling edge; P=2295 (0x08F7); P[7:0]=247.
2. A=8, B=100 -> P=800 (0x0320); P[7:0]=32; busy high for exactly 8 cycles; done high for 1 cycle.
3. Corners: A=255, B=255 -> P=65025; A=0, B=200 -> P=0; A=1, B=1 -> P=1; back-to-back with start held high -> two correct results 10 clocks apart.
4. Run A=9, B=255 first, then start A=3, B=7 while busy -> second start ignored; P=2295. Applying A=3, B=7 after returning to IDLE -> P=21.
5. Assert reset in the 4th RUN cycle -> next edge: P=0, busy=0, done=0, state IDLE; no done pulse follows.
6. Change A/B mid-RUN (A=9, B=255 latched, then inputs change to 1, 1) -> P=2295 unaffected.
